// File: rtl/usb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// usb_bus_arbiter
//
// Purpose:
//   Arbitrates a byte-wide USB FIFO bridge (FT245-style) between host-to-device
//   reads and up to three device-side transmit requesters. Reads and whole
//   write packets are interleaved fairly. Write requesters are picked
//   round-robin, and a granted requester keeps the write port until its packet
//   ends.
//
// Optional feature:
//   USB_ARB_TIMEOUT_EN - when defined, a 16-bit wait counter abandons a write
//   packet that has stalled in WR_WAIT (txe_n held high). The abandon is
//   reported with a one-cycle timeout pulse. When the macro is undefined,
//   WR_WAIT waits indefinitely and timeout is tied low.
//
// Ports:
//   clk              in   system clock, all logic on the rising edge
//   reset            in   synchronous active-high reset
//   rxf_n            in   FIFO holds a host byte (active low)
//   txe_n            in   FIFO can accept a byte (active low)
//   rx_data_in[7:0]  in   FIFO data bus, read direction
//   req[2:0]         in   per-requester transmit request
//   req_data0/1/2    in   requester bytes, held stable until acknowledged
//   req_last[2:0]    in   current byte is the last of its packet
//   grant[2:0]       out  one-hot owner of the write port
//   ack[2:0]         out  one-cycle pulse, granted byte was written
//   data_out[7:0]    out  FIFO data bus, write direction
//   data_out_enable  out  drive data_out onto the bus
//   rd_n             out  FIFO read strobe (active low)
//   wr_n             out  FIFO write strobe (active low)
//   rx_byte[7:0]     out  last byte read from the host
//   rx_valid         out  one-cycle pulse, rx_byte updated
//   timeout          out  one-cycle pulse, write packet abandoned
//   state_out[3:0]   out  current FSM state encoding
// -----------------------------------------------------------------------------
module usb_bus_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxf_n,
  input  logic       txe_n,
  input  logic [7:0] rx_data_in,
  input  logic [2:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  input  logic [2:0] req_last,
  output logic [2:0] grant,
  output logic [2:0] ack,
  output logic [7:0] data_out,
  output logic       data_out_enable,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       timeout,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD1      = 4'd1,
    RD2      = 4'd2,
    RD3      = 4'd3,
    RD_END   = 4'd4,
    WR_WAIT  = 4'd5,
    WR_SETUP = 4'd6,
    WR_LO1   = 4'd7,
    WR_LO2   = 4'd8,
    WR_HI    = 4'd9
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] rr;
  logic [1:0] rr_nx;
  logic [1:0] owner;
  logic [1:0] owner_nx;
  logic [2:0] grant_nx;
  logic       last_was_read;
  logic       last_was_read_nx;

  logic [7:0] owner_data;
  logic       owner_req;
  logic       owner_last;
  logic [1:0] owner_inc;
  logic [1:0] pick;

  logic       rd_strobe_nx;
  logic       wr_strobe_nx;
  logic       wr_phase_nx;
  logic       rd_done_nx;
  logic       wr_hi_nx;

`ifdef USB_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nx;
  logic        timeout_q;
  logic        timeout_nx;
`endif

  // Round-robin search: scan offsets rr, rr+1, rr+2 (mod 3) and return the
  // first index with its request set. The scan runs from the farthest offset
  // to the nearest, so the nearest hit is the one that survives.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] s;
    logic [1:0] res;
    res = p;
    for (int k = 2; k >= 0; k--) begin
      s = {1'b0, p} + 3'(k);
      if (s > 3'd2) s = s - 3'd3;
      if (r[s[1:0]]) res = s[1:0];
    end
    return res;
  endfunction

  // Select the byte, request and last flag of the requester that currently
  // owns the write port. owner is held as an index next to the one-hot grant,
  // so no decoder is needed. rr advances to the slot after the owner when a
  // packet ends.
  always_comb begin
    owner_data = 8'h00;
    owner_req  = 1'b0;
    owner_last = 1'b0;
    case (owner)
      2'd0: begin
        owner_data = req_data0;
        owner_req  = req[0];
        owner_last = req_last[0];
      end
      2'd1: begin
        owner_data = req_data1;
        owner_req  = req[1];
        owner_last = req_last[1];
      end
      default: begin
        owner_data = req_data2;
        owner_req  = req[2];
        owner_last = req_last[2];
      end
    endcase
    owner_inc = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    pick      = rr_pick(req, rr);
  end

  // Next-state decode. Reads start only from IDLE, so a write packet is never
  // split by a read. When both classes are pending, last_was_read gives the
  // turn to the class that was not served last. last_was_read is cleared as
  // soon as a write is granted, so it already reads 0 when the packet ends.
  always_comb begin
    state_nx         = state;
    grant_nx         = grant;
    owner_nx         = owner;
    rr_nx            = rr;
    last_was_read_nx = last_was_read;
`ifdef USB_ARB_TIMEOUT_EN
    wait_cnt_nx      = wait_cnt;
    timeout_nx       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxf_n && (!(|req) || !last_was_read)) begin
          state_nx         = RD1;
          last_was_read_nx = 1'b1;
        end else if (|req) begin
          state_nx         = WR_WAIT;
          owner_nx         = pick;
          grant_nx         = 3'b001 << pick;
          last_was_read_nx = 1'b0;
`ifdef USB_ARB_TIMEOUT_EN
          wait_cnt_nx      = 16'h0000;
`endif
        end
      end
      RD1:    state_nx = RD2;
      RD2:    state_nx = RD3;
      RD3:    state_nx = RD_END;
      RD_END: state_nx = IDLE;
      WR_WAIT: begin
        if (!owner_req) begin
          state_nx = IDLE;
          grant_nx = 3'b000;
          rr_nx    = owner_inc;
        end else if (!txe_n) begin
          state_nx = WR_SETUP;
        end else begin
`ifdef USB_ARB_TIMEOUT_EN
          // The counter reaching 16'hFFFF ends the wait, so the decision is
          // taken on the increment out of 16'hFFFE.
          wait_cnt_nx = wait_cnt + 16'h0001;
          if (wait_cnt == 16'hFFFE) begin
            state_nx   = IDLE;
            grant_nx   = 3'b000;
            rr_nx      = owner_inc;
            timeout_nx = 1'b1;
          end
`endif
        end
      end
      WR_SETUP: state_nx = WR_LO1;
      WR_LO1:   state_nx = WR_LO2;
      WR_LO2:   state_nx = WR_HI;
      WR_HI: begin
        if (owner_last) begin
          state_nx         = IDLE;
          grant_nx         = 3'b000;
          rr_nx            = owner_inc;
          last_was_read_nx = 1'b0;
        end else begin
          state_nx = WR_WAIT;
`ifdef USB_ARB_TIMEOUT_EN
          wait_cnt_nx = 16'h0000;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 3'b000;
      end
    endcase
  end

  // Strobe and flag decode from the next state. Registering these together
  // with the state keeps every output glitch-free and aligned with state_out.
  always_comb begin
    rd_strobe_nx = (state_nx == RD1) || (state_nx == RD2) || (state_nx == RD3);
    wr_strobe_nx = (state_nx == WR_LO1) || (state_nx == WR_LO2);
    wr_phase_nx  = (state_nx == WR_WAIT) || (state_nx == WR_SETUP) ||
                   (state_nx == WR_LO1)  || (state_nx == WR_LO2)   ||
                   (state_nx == WR_HI);
    rd_done_nx   = (state_nx == RD_END);
    wr_hi_nx     = (state_nx == WR_HI);
  end

  // State register and registered outputs. Reset is synchronous, so an
  // active strobe is released on the first edge that samples reset high.
  // rx_byte captures the bus on the RD3 -> RD_END edge and is then held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= 3'b000;
      owner           <= 2'd0;
      rr              <= 2'd0;
      last_was_read   <= 1'b0;
      rd_n            <= 1'b1;
      wr_n            <= 1'b1;
      ack             <= 3'b000;
      rx_valid        <= 1'b0;
      rx_byte         <= 8'h00;
      data_out_enable <= 1'b0;
`ifdef USB_ARB_TIMEOUT_EN
      wait_cnt        <= 16'h0000;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state           <= state_nx;
      grant           <= grant_nx;
      owner           <= owner_nx;
      rr              <= rr_nx;
      last_was_read   <= last_was_read_nx;
      rd_n            <= !rd_strobe_nx;
      wr_n            <= !wr_strobe_nx;
      ack             <= wr_hi_nx ? grant_nx : 3'b000;
      rx_valid        <= rd_done_nx;
      data_out_enable <= wr_phase_nx;
      if (state == RD3) rx_byte <= rx_data_in;
`ifdef USB_ARB_TIMEOUT_EN
      wait_cnt        <= wait_cnt_nx;
      timeout_q       <= timeout_nx;
`endif
    end
  end

  // The bus shows the owner's byte only while the port is enabled. The byte
  // comes live from the requester, which holds it stable until its ack.
  assign data_out  = data_out_enable ? owner_data : 8'h00;
  assign state_out = state;

`ifdef USB_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_usb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_bus_arbiter
//
// Purpose:
//   Self-checking bench for usb_bus_arbiter. Each scenario task pushes the
//   results it expects into scoreboard queues while driving stimulus. It then
//   pops and compares those entries as the DUT produces reads, acks and grants.
//   Inputs change on the falling edge and outputs are sampled there, away from
//   the active rising edge.
// -----------------------------------------------------------------------------
module tb_usb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxf_n = 1'b1;
  logic       txe_n = 1'b1;
  logic [7:0] rx_data_in = 8'h00;
  logic [2:0] req = 3'b000;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic [7:0] req_data2 = 8'h00;
  logic [2:0] req_last = 3'b000;
  logic [2:0] grant;
  logic [2:0] ack;
  logic [7:0] data_out;
  logic       data_out_enable;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       timeout;
  logic [3:0] state_out;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_rx_q[$];
  logic [10:0] exp_wr_q[$];
  bit          exp_op_q[$];

  usb_bus_arbiter dut (
    .clk(clk), .reset(reset), .rxf_n(rxf_n), .txe_n(txe_n),
    .rx_data_in(rx_data_in), .req(req), .req_data0(req_data0),
    .req_data1(req_data1), .req_data2(req_data2), .req_last(req_last),
    .grant(grant), .ack(ack), .data_out(data_out),
    .data_out_enable(data_out_enable), .rd_n(rd_n), .wr_n(wr_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .timeout(timeout),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Holds reset for two edges with all inputs idle, then releases it on a
  // falling edge and empties the scoreboards.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rxf_n = 1'b1; txe_n = 1'b1; req = 3'b000; req_last = 3'b000;
    rx_data_in = 8'h00; req_data0 = 8'h00; req_data1 = 8'h00; req_data2 = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rx_q.delete(); exp_wr_q.delete(); exp_op_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (state_out !== 4'd0) begin
      n_err++; $display("[TB] FAIL reset_state: got %0d expected 0", state_out);
    end
    n_vec++;
    if ({rd_n, wr_n, data_out_enable, rx_valid, timeout} !== 5'b11000) begin
      n_err++; $display("[TB] FAIL reset_strobes: got %b expected 11000",
                        {rd_n, wr_n, data_out_enable, rx_valid, timeout});
    end
    n_vec++;
    if ({grant, ack} !== 6'b000000) begin
      n_err++; $display("[TB] FAIL reset_grant_ack: got %b expected 000000", {grant, ack});
    end
    n_vec++;
    if ({data_out, rx_byte} !== 16'h0000) begin
      n_err++; $display("[TB] FAIL reset_data: got %h expected 0000", {data_out, rx_byte});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({state_out, rd_n, wr_n, grant} !== {4'd0, 1'b1, 1'b1, 3'b000}) begin
      n_err++; $display("[TB] FAIL reset_idle_hold: got %b expected 0000_1_1_000",
                        {state_out, rd_n, wr_n, grant});
    end
  endtask

  task automatic test_read();
    logic [7:0] vals [2];
    logic [7:0] exp;
    int low, vcount, last_low, vcyc;
    vals[0] = 8'hA5; vals[1] = 8'h3C;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      rx_data_in = vals[b]; rxf_n = 1'b0;
      exp_rx_q.push_back(vals[b]);
      low = 0; vcount = 0; last_low = -10; vcyc = -1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!rd_n && (!wr_n || data_out_enable)) begin
          n_vec++; n_err++;
          $display("[TB] FAIL read_bus_excl: got wr_n=%b doe=%b expected 1/0", wr_n, data_out_enable);
        end
        if (!rd_n) begin low++; last_low = c; rxf_n = 1'b1; end
        if (rx_valid) begin
          vcount++; vcyc = c;
          n_vec++;
          if (exp_rx_q.size() == 0) begin
            n_err++; $display("[TB] FAIL read_extra_valid: got rx_byte=%h expected none", rx_byte);
          end else begin
            exp = exp_rx_q.pop_front();
            if (rx_byte !== exp) begin
              n_err++; $display("[TB] FAIL read_byte: got %h expected %h", rx_byte, exp);
            end
          end
        end
      end
      n_vec++;
      if (low != 3) begin
        n_err++; $display("[TB] FAIL read_rd_low_cycles: got %0d expected 3", low);
      end
      n_vec++;
      if (vcount != 1 || vcyc != last_low + 1) begin
        n_err++; $display("[TB] FAIL read_valid_timing: got count=%0d at %0d expected 1 at %0d",
                          vcount, vcyc, last_low + 1);
      end
      n_vec++;
      if (state_out !== 4'd0 || rx_byte !== vals[b]) begin
        n_err++; $display("[TB] FAIL read_end_hold: got state=%0d rx_byte=%h expected 0 %h",
                          state_out, rx_byte, vals[b]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [10:0] exp;
    int acks, wlow;
    do_reset();
    req_data0 = 8'hA0; req_data1 = 8'hB1; req_data2 = 8'hC2;
    req_last = 3'b111; txe_n = 1'b0; req = 3'b111;
    exp_wr_q.push_back({3'b001, 8'hA0});
    exp_wr_q.push_back({3'b010, 8'hB1});
    exp_wr_q.push_back({3'b100, 8'hC2});
    exp_wr_q.push_back({3'b001, 8'hA0});
    acks = 0; wlow = 0;
    for (int c = 0; c < 80 && acks < 4; c++) begin
      @(negedge clk);
      if (!rd_n) begin
        n_vec++; n_err++; $display("[TB] FAIL rr_no_read: got rd_n=0 expected 1");
      end
      if (!wr_n && exp_wr_q.size() != 0) begin
        wlow++;
        n_vec++;
        if ({grant, data_out} !== exp_wr_q[0] || data_out_enable !== 1'b1) begin
          n_err++; $display("[TB] FAIL rr_write_bus: got grant=%b data=%h doe=%b expected %b %h 1",
                            grant, data_out, data_out_enable, exp_wr_q[0][10:8], exp_wr_q[0][7:0]);
        end
      end
      if (ack !== 3'b000) begin
        n_vec++;
        if (exp_wr_q.size() == 0) begin
          n_err++; $display("[TB] FAIL rr_extra_ack: got %b expected none", ack);
        end else begin
          exp = exp_wr_q.pop_front();
          if (ack !== exp[10:8] || wlow != 2) begin
            n_err++; $display("[TB] FAIL rr_ack: got ack=%b wr_low=%0d expected %b 2",
                              ack, wlow, exp[10:8]);
          end
        end
        wlow = 0; acks++;
        if (acks == 4) req = 3'b000;
      end
    end
    n_vec++;
    if (acks != 4) begin
      n_err++; $display("[TB] FAIL rr_ack_count: got %0d expected 4", acks);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({state_out, grant, data_out_enable} !== 8'b0000_000_0) begin
      n_err++; $display("[TB] FAIL rr_release: got state=%0d grant=%b doe=%b expected 0 000 0",
                        state_out, grant, data_out_enable);
    end
  endtask

  task automatic test_alternate();
    bit exp;
    do_reset();
    rx_data_in = 8'h77; req_data1 = 8'h5A; req_last = 3'b111;
    txe_n = 1'b0; rxf_n = 1'b0; req = 3'b010;
    for (int i = 0; i < 6; i++) exp_op_q.push_back(i[0]);
    for (int c = 0; c < 120 && exp_op_q.size() != 0; c++) begin
      @(negedge clk);
      if ((!rd_n && !wr_n) || (!rd_n && data_out_enable)) begin
        n_vec++; n_err++;
        $display("[TB] FAIL alt_bus_excl: got rd_n=%b wr_n=%b doe=%b expected no overlap",
                 rd_n, wr_n, data_out_enable);
      end
      if (rx_valid) begin
        exp = exp_op_q.pop_front();
        n_vec++;
        if (exp !== 1'b0 || rx_byte !== 8'h77) begin
          n_err++; $display("[TB] FAIL alt_read_turn: got read byte=%h expected op=%0d byte 77",
                            rx_byte, exp);
        end
      end
      if (ack !== 3'b000 && exp_op_q.size() != 0) begin
        exp = exp_op_q.pop_front();
        n_vec++;
        if (exp !== 1'b1 || ack !== 3'b010) begin
          n_err++; $display("[TB] FAIL alt_write_turn: got ack=%b expected op=%0d ack 010", ack, exp);
        end
      end
    end
    rxf_n = 1'b1; req = 3'b000;
    n_vec++;
    if (exp_op_q.size() != 0) begin
      n_err++; $display("[TB] FAIL alt_ops_done: got %0d pending expected 0", exp_op_q.size());
    end
  endtask

  task automatic test_packet();
    logic [10:0] exp;
    int acks, rd_early, rd_seen, last_ack, gap_bad, got;
    do_reset();
    req_data0 = 8'h11; req_last = 3'b000; txe_n = 1'b0; req = 3'b001;
    exp_wr_q.push_back({3'b001, 8'h11});
    exp_wr_q.push_back({3'b001, 8'h12});
    exp_wr_q.push_back({3'b001, 8'h13});
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (grant === 3'b001) got = 1;
    end
    n_vec++;
    if (got == 0) begin
      n_err++; $display("[TB] FAIL pkt_grant_wait: got grant=%b expected 001", grant);
    end
    rxf_n = 1'b0; rx_data_in = 8'h99;
    exp_rx_q.push_back(8'h99);
    acks = 0; rd_early = 0; last_ack = -1; gap_bad = 0;
    for (int c = 0; c < 80 && acks < 3; c++) begin
      @(negedge clk);
      if (!rd_n) rd_early++;
      if (!wr_n && exp_wr_q.size() != 0) begin
        n_vec++;
        if (data_out !== exp_wr_q[0][7:0]) begin
          n_err++; $display("[TB] FAIL pkt_data: got %h expected %h", data_out, exp_wr_q[0][7:0]);
        end
      end
      if (ack !== 3'b000) begin
        if (last_ack >= 0 && c - last_ack != 5) gap_bad++;
        last_ack = c;
        n_vec++;
        if (exp_wr_q.size() == 0) begin
          n_err++; $display("[TB] FAIL pkt_extra_ack: got %b expected none", ack);
        end else begin
          exp = exp_wr_q.pop_front();
          if (ack !== exp[10:8]) begin
            n_err++; $display("[TB] FAIL pkt_ack: got %b expected %b", ack, exp[10:8]);
          end
        end
        acks++;
        @(posedge clk); #1;
        if (acks == 1) req_data0 = 8'h12;
        if (acks == 2) begin req_data0 = 8'h13; req_last = 3'b001; end
        if (acks == 3) begin req = 3'b000; req_last = 3'b000; end
      end
    end
    n_vec++;
    if (acks != 3 || rd_early != 0) begin
      n_err++; $display("[TB] FAIL pkt_no_read: got acks=%0d rd_low=%0d expected 3 0", acks, rd_early);
    end
    n_vec++;
    if (gap_bad != 0) begin
      n_err++; $display("[TB] FAIL pkt_byte_rate: got %0d bad gaps expected 0", gap_bad);
    end
    rd_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!rd_n) begin rd_seen = 1; rxf_n = 1'b1; end
      if (rx_valid && exp_rx_q.size() != 0) begin
        n_vec++;
        if (rx_byte !== exp_rx_q[0]) begin
          n_err++; $display("[TB] FAIL pkt_read_after: got %h expected %h", rx_byte, exp_rx_q[0]);
        end
        void'(exp_rx_q.pop_front());
      end
    end
    n_vec++;
    if (rd_seen == 0 || exp_rx_q.size() != 0) begin
      n_err++; $display("[TB] FAIL pkt_read_served: got rd_seen=%0d pending=%0d expected 1 0",
                        rd_seen, exp_rx_q.size());
    end
  endtask

  task automatic test_reset_midstrobe();
    int got, bad;
    do_reset();
    req = 3'b100; req_data2 = 8'hE7; req_last = 3'b111; txe_n = 1'b0;
    got = 0;
    for (int c = 0; c < 12 && got == 0; c++) begin
      @(negedge clk);
      if (!wr_n) got = 1;
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (got == 0 || {wr_n, grant, data_out_enable, ack, state_out} !== {1'b1, 3'b000, 1'b0, 3'b000, 4'd0}) begin
      n_err++; $display("[TB] FAIL rst_mid_write: got seen=%0d wr_n=%b grant=%b doe=%b ack=%b state=%0d expected 1 1 000 0 000 0",
                        got, wr_n, grant, data_out_enable, ack, state_out);
    end
    req = 3'b000; reset = 1'b0;
    rxf_n = 1'b0; rx_data_in = 8'h42;
    got = 0;
    for (int c = 0; c < 12 && got == 0; c++) begin
      @(negedge clk);
      if (!rd_n) got = 1;
    end
    @(negedge clk);
    reset = 1'b1; rxf_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (got == 0 || {rd_n, rx_valid, rx_byte, state_out} !== {1'b1, 1'b0, 8'h00, 4'd0}) begin
      n_err++; $display("[TB] FAIL rst_mid_read: got seen=%0d rd_n=%b rx_valid=%b rx_byte=%h state=%0d expected 1 1 0 00 0",
                        got, rd_n, rx_valid, rx_byte, state_out);
    end
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rx_valid || ack !== 3'b000) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("[TB] FAIL rst_no_late_pulse: got %0d pulses expected 0", bad);
    end
  endtask

  task automatic test_req_drop();
    logic [10:0] exp;
    int got, bad;
    do_reset();
    txe_n = 1'b1; req = 3'b010; req_last = 3'b111;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (grant === 3'b010) got = 1;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (got == 0 || {state_out, grant, wr_n} !== {4'd5, 3'b010, 1'b1}) begin
      n_err++; $display("[TB] FAIL drop_waiting: got seen=%0d state=%0d grant=%b wr_n=%b expected 1 5 010 1",
                        got, state_out, grant, wr_n);
    end
    req = 3'b000;
    @(negedge clk);
    n_vec++;
    if ({state_out, grant, ack} !== {4'd0, 3'b000, 3'b000}) begin
      n_err++; $display("[TB] FAIL drop_release: got state=%0d grant=%b ack=%b expected 0 000 000",
                        state_out, grant, ack);
    end
    // Requester 1 ended its packet, so the pointer now starts at 2: with
    // requesters 0 and 1 asking, the scan 2,0,1 lands on requester 0.
    exp_wr_q.push_back({3'b001, 8'hD0});
    req_data0 = 8'hD0; txe_n = 1'b0; req = 3'b011;
    got = 0; bad = 0;
    for (int c = 0; c < 20 && exp_wr_q.size() != 0; c++) begin
      @(negedge clk);
      if (grant !== 3'b000 && got == 0) begin
        got = 1;
        n_vec++;
        if (grant !== exp_wr_q[0][10:8]) begin
          n_err++; $display("[TB] FAIL drop_rr_next: got %b expected %b", grant, exp_wr_q[0][10:8]);
        end
      end
      if (ack !== 3'b000) begin
        exp = exp_wr_q.pop_front();
        n_vec++;
        if (ack !== exp[10:8]) begin
          n_err++; $display("[TB] FAIL drop_ack: got %b expected %b", ack, exp[10:8]);
        end
        req = 3'b000;
      end
    end
    n_vec++;
    if (exp_wr_q.size() != 0) begin
      n_err++; $display("[TB] FAIL drop_ack_wait: got %0d pending expected 0", exp_wr_q.size());
    end
  endtask

  task automatic test_timeout();
    int got, n, pulses;
    do_reset();
    req = 3'b100; txe_n = 1'b1; req_last = 3'b111;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (grant === 3'b100) got = 1;
    end
`ifdef USB_ARB_TIMEOUT_EN
    n = 0; pulses = 0;
    for (int c = 0; c < 70000 && pulses == 0; c++) begin
      @(negedge clk);
      n++;
      if (timeout) pulses = 1;
    end
    n_vec++;
    if (got == 0 || pulses == 0 || n != 65535) begin
      n_err++; $display("[TB] FAIL timeout_delay: got seen=%0d pulse=%0d after %0d expected 1 1 65535",
                        got, pulses, n);
    end
    n_vec++;
    if ({grant, state_out} !== {3'b000, 4'd0}) begin
      n_err++; $display("[TB] FAIL timeout_release: got grant=%b state=%0d expected 000 0", grant, state_out);
    end
    req = 3'b000;
    @(negedge clk);
    n_vec++;
    if (timeout !== 1'b0) begin
      n_err++; $display("[TB] FAIL timeout_one_cycle: got %b expected 0", timeout);
    end
`else
    n = 0; pulses = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n++;
      if (timeout !== 1'b0) pulses++;
    end
    n_vec++;
    if (got == 0 || pulses != 0 || {grant, state_out} !== {3'b100, 4'd5}) begin
      n_err++; $display("[TB] FAIL wait_forever: got seen=%0d pulses=%0d grant=%b state=%0d after %0d expected 1 0 100 5",
                        got, pulses, grant, state_out, n);
    end
    req = 3'b000;
`endif
  endtask

  initial begin
    $display("[TB] usb_bus_arbiter bench start");
    test_reset();
    test_read();
    test_round_robin();
    test_alternate();
    test_packet();
    test_reset_midstrobe();
    test_req_drop();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
